// File: rtl/move_sched_if.sv
// Collision-checker and movement-datapath bus shared by the
// frame sequencer (master) and the physics units (slave).
interface move_sched_if;
   logic       coll_req;
   logic       coll_char;
   logic       coll_ack;
   logic [1:0] coll_state_in;
   logic [1:0] move_en;
   logic [9:0] cur_x;
   logic [8:0] cur_y;
   logic [1:0] collision_state;
   logic [9:0] new_x;
   logic [8:0] new_y;

   modport master (
      output coll_req, coll_char, move_en,
      output cur_x, cur_y, collision_state,
      input  coll_ack, coll_state_in, new_x, new_y
   );

   modport slave (
      input  coll_req, coll_char, move_en,
      input  cur_x, cur_y, collision_state,
      output coll_ack, coll_state_in, new_x, new_y
   );
endinterface

// File: rtl/move_scheduler.sv
// Per-frame physics sequencer: time-shares one collision checker and
// one movement datapath between blue then red, owning their positions.
module move_scheduler #(
   parameter logic [9:0] BLUE_X0     = 10'd40,
   parameter logic [8:0] BLUE_Y0     = 9'd400,
   parameter logic [9:0] RED_X0      = 10'd80,
   parameter logic [8:0] RED_Y0      = 9'd400,
   parameter logic [7:0] ACK_TIMEOUT = 8'd63,
   parameter int         MOVE_LAT    = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         frame_tick,
   move_sched_if.master bus,
   output logic [9:0]   blue_x,
   output logic [8:0]   blue_y,
   output logic [9:0]   red_x,
   output logic [8:0]   red_y,
   output logic         busy,
   output logic         frame_done,
   output logic         overrun,
   output logic         ack_timeout
);
   typedef enum logic [2:0] {
      IDLE, REQ, MOVE, WAIT, COMMIT, DONE
   } state_t;

   localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 8'd1);
   localparam logic [7:0] WAIT_LAST =
      8'((MOVE_LAT > 1) ? MOVE_LAT - 2 : 0);

   state_t     state, state_nx;
   logic       ch, ch_nx;
   logic [7:0] cnt, cnt_nx;
   logic [1:0] blue_cs, red_cs;
   logic       req_to;

   assign req_to = !bus.coll_ack && (cnt == TO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ch    <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         ch    <= ch_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      ch_nx    = ch;
      cnt_nx   = cnt;
      unique case (state)
         IDLE: begin
            if (frame_tick) begin
               state_nx = REQ;
               ch_nx    = 1'b0;
               cnt_nx   = '0;
            end
         end
         REQ: begin
            if (bus.coll_ack || req_to) begin
               state_nx = MOVE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 8'd1;
            end
         end
         MOVE: begin
            // a one-cycle datapath needs no wait slot at all
            state_nx = (MOVE_LAT > 1) ? WAIT : COMMIT;
            cnt_nx   = '0;
         end
         WAIT: begin
            if (cnt == WAIT_LAST) begin
               state_nx = COMMIT;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 8'd1;
            end
         end
         COMMIT: begin
            cnt_nx = '0;
            if (!ch) begin
               ch_nx    = 1'b1;
               state_nx = REQ;
            end else begin
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blue_x      <= BLUE_X0;
         blue_y      <= BLUE_Y0;
         red_x       <= RED_X0;
         red_y       <= RED_Y0;
         blue_cs     <= '0;
         red_cs      <= '0;
         overrun     <= 1'b0;
         ack_timeout <= 1'b0;
      end else begin
         if (frame_tick && state != IDLE)
            overrun <= 1'b1;
         if (state == REQ) begin
            if (bus.coll_ack) begin
               if (ch) red_cs  <= bus.coll_state_in;
               else    blue_cs <= bus.coll_state_in;
            end else if (req_to) begin
               if (ch) red_cs  <= 2'b00;
               else    blue_cs <= 2'b00;
               ack_timeout <= 1'b1;
            end
         end
         if (state == COMMIT) begin
            if (ch) begin
               red_x <= bus.new_x;
               red_y <= bus.new_y;
            end else begin
               blue_x <= bus.new_x;
               blue_y <= bus.new_y;
            end
         end
      end
   end

   assign bus.coll_req        = (state == REQ);
   assign bus.coll_char       = ch;
   assign bus.move_en         = (state == MOVE) ? (ch ? 2'b10 : 2'b01)
                                                : 2'b00;
   assign bus.cur_x           = ch ? red_x  : blue_x;
   assign bus.cur_y           = ch ? red_y  : blue_y;
   assign bus.collision_state = ch ? red_cs : blue_cs;
   assign busy                = (state != IDLE);
   assign frame_done          = (state == DONE);
endmodule

// File: tb/tb_move_scheduler.sv
// Scoreboard bench: stimulus queues expected move strobes and frame
// results; a negedge monitor pops and compares whenever the DUT emits.
module tb_move_scheduler;
   typedef struct {
      logic [1:0] en;
      logic [9:0] x;
      logic [8:0] y;
      logic [1:0] cs;
   } mv_t;

   typedef struct {
      logic [9:0] bx;
      logic [8:0] by;
      logic [9:0] rx;
      logic [8:0] ry;
      logic       ovr;
      logic       ato;
   } dn_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic tick = 1'b0;
   logic tick2 = 1'b0;
   logic [9:0] bx, rx, bx2, rx2;
   logic [8:0] by, ry, by2, ry2;
   logic busy, done, ovr, ato;
   logic busy2, done2, ovr2, ato2;

   int n_chk = 0;
   int n_fail = 0;

   mv_t mv_q[$];
   dn_t dn_q[$];
   dn_t dn2_q[$];

   move_sched_if bus();
   move_sched_if bus2();

   always #5 clk = ~clk;

   move_scheduler dut (
      .clk(clk), .rst_n(rst_n), .frame_tick(tick), .bus(bus),
      .blue_x(bx), .blue_y(by), .red_x(rx), .red_y(ry),
      .busy(busy), .frame_done(done),
      .overrun(ovr), .ack_timeout(ato)
   );

   move_scheduler #(.MOVE_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .frame_tick(tick2), .bus(bus2),
      .blue_x(bx2), .blue_y(by2), .red_x(rx2), .red_y(ry2),
      .busy(busy2), .frame_done(done2),
      .overrun(ovr2), .ack_timeout(ato2)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic expire(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s: wait bound expired", nm);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.move_en != 2'b00) begin
            if (mv_q.size() == 0) begin
               expire("unexpected_move_en");
            end else begin
               mv_t m;
               m = mv_q.pop_front();
               chk("move_en", 32'(bus.move_en), 32'(m.en));
               chk("cur_x", 32'(bus.cur_x), 32'(m.x));
               chk("cur_y", 32'(bus.cur_y), 32'(m.y));
               chk("coll_state", 32'(bus.collision_state), 32'(m.cs));
            end
         end
         if (done) begin
            if (dn_q.size() == 0) begin
               expire("unexpected_frame_done");
            end else begin
               dn_t d;
               d = dn_q.pop_front();
               chk("blue_x", 32'(bx), 32'(d.bx));
               chk("blue_y", 32'(by), 32'(d.by));
               chk("red_x", 32'(rx), 32'(d.rx));
               chk("red_y", 32'(ry), 32'(d.ry));
               chk("overrun", 32'(ovr), 32'(d.ovr));
               chk("ack_timeout", 32'(ato), 32'(d.ato));
            end
         end
         if (done2) begin
            if (dn2_q.size() == 0) begin
               expire("unexpected_frame_done_lat3");
            end else begin
               dn_t d;
               d = dn2_q.pop_front();
               chk("lat3_blue_x", 32'(bx2), 32'(d.bx));
               chk("lat3_blue_y", 32'(by2), 32'(d.by));
               chk("lat3_red_x", 32'(rx2), 32'(d.rx));
               chk("lat3_red_y", 32'(ry2), 32'(d.ry));
            end
         end
      end
   end

   task automatic pulse_tick();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic wait_req(input logic c);
      int i;
      for (i = 0; i < 200 && !bus.coll_req; i++) @(negedge clk);
      if (!bus.coll_req) expire("wait_coll_req");
      else chk("coll_char", 32'(bus.coll_char), 32'(c));
   endtask

   task automatic wait_move();
      int i;
      for (i = 0; i < 20 && bus.move_en == 2'b00; i++) @(negedge clk);
      if (bus.move_en == 2'b00) expire("wait_move_en");
   endtask

   task automatic wait_done();
      int i;
      for (i = 0; i < 40 && !done; i++) @(negedge clk);
      if (!done) expire("wait_frame_done");
      @(negedge clk);
      chk("busy_after_done", 32'(busy), 32'd0);
   endtask

   // ack_dly < 0 means the checker never answers
   task automatic slot(input logic c, input int ack_dly,
                       input logic [1:0] av, input logic [9:0] nx,
                       input logic [8:0] ny, input bit tick_in_wait);
      wait_req(c);
      if (ack_dly < 0) begin
         int n;
         n = 0;
         while (bus.coll_req && n < 200) begin
            n++;
            @(negedge clk);
         end
         chk("req_hold_cycles", 32'(n), 32'd63);
         chk("ack_timeout_set", 32'(ato), 32'd1);
      end else begin
         repeat (ack_dly) @(negedge clk);
         bus.coll_ack = 1'b1;
         bus.coll_state_in = av;
         @(negedge clk);
         bus.coll_ack = 1'b0;
         bus.coll_state_in = 2'b00;
      end
      wait_move();
      bus.new_x = nx;
      bus.new_y = ny;
      if (tick_in_wait) begin
         @(negedge clk);
         pulse_tick();
      end
   endtask

   task automatic lat3_slot(input logic [9:0] base, input logic [8:0] ny);
      int i;
      for (i = 0; i < 200 && !bus2.coll_req; i++) @(negedge clk);
      if (!bus2.coll_req) expire("lat3_wait_req");
      bus2.coll_ack = 1'b1;
      bus2.coll_state_in = 2'b01;
      @(negedge clk);
      bus2.coll_ack = 1'b0;
      for (i = 0; i < 20 && bus2.move_en == 2'b00; i++) @(negedge clk);
      if (bus2.move_en == 2'b00) expire("lat3_wait_move");
      bus2.new_y = ny;
      for (int k = 0; k < 4; k++) begin
         bus2.new_x = base + 10'(10 * k);
         @(negedge clk);
      end
   endtask

   initial begin
      bus.coll_ack = 1'b0;
      bus.coll_state_in = 2'b00;
      bus.new_x = '0;
      bus.new_y = '0;
      bus2.coll_ack = 1'b0;
      bus2.coll_state_in = 2'b00;
      bus2.new_x = '0;
      bus2.new_y = '0;

      repeat (3) @(negedge clk);
      chk("rst_blue_x", 32'(bx), 32'd40);
      chk("rst_blue_y", 32'(by), 32'd400);
      chk("rst_red_x", 32'(rx), 32'd80);
      chk("rst_red_y", 32'(ry), 32'd400);
      chk("rst_flags", 32'({busy, done, ovr, ato, bus.coll_req}), 32'd0);
      chk("rst_move_en", 32'(bus.move_en), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      mv_q.push_back('{2'b01, 10'd40, 9'd400, 2'b01});
      mv_q.push_back('{2'b10, 10'd80, 9'd400, 2'b10});
      dn_q.push_back('{10'd41, 9'd399, 10'd81, 9'd398, 1'b0, 1'b0});
      pulse_tick();
      slot(1'b0, 3, 2'b01, 10'd41, 9'd399, 1'b0);
      slot(1'b1, 0, 2'b10, 10'd81, 9'd398, 1'b0);
      wait_done();

      mv_q.push_back('{2'b01, 10'd41, 9'd399, 2'b00});
      mv_q.push_back('{2'b10, 10'd81, 9'd398, 2'b00});
      dn_q.push_back('{10'd50, 9'd390, 10'd90, 9'd380, 1'b0, 1'b1});
      pulse_tick();
      slot(1'b0, -1, 2'b00, 10'd50, 9'd390, 1'b0);
      slot(1'b1, -1, 2'b00, 10'd90, 9'd380, 1'b0);
      wait_done();

      mv_q.push_back('{2'b01, 10'd50, 9'd390, 2'b11});
      mv_q.push_back('{2'b10, 10'd90, 9'd380, 2'b01});
      dn_q.push_back('{10'd60, 9'd380, 10'd95, 9'd370, 1'b1, 1'b1});
      pulse_tick();
      slot(1'b0, 0, 2'b11, 10'd60, 9'd380, 1'b1);
      slot(1'b1, 1, 2'b01, 10'd95, 9'd370, 1'b0);
      wait_done();
      repeat (30) @(negedge clk);
      chk("no_second_frame", 32'(busy), 32'd0);

      mv_q.push_back('{2'b01, 10'd60, 9'd380, 2'b00});
      pulse_tick();
      slot(1'b0, 0, 2'b00, 10'd70, 9'd375, 1'b0);
      wait_req(1'b1);
      chk("mid_blue_x_committed", 32'(bx), 32'd70);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_coll_req", 32'(bus.coll_req), 32'd0);
      chk("mid_rst_blue", 32'({bx, by}), 32'({10'd40, 9'd400}));
      chk("mid_rst_red", 32'({rx, ry}), 32'({10'd80, 9'd400}));
      chk("mid_rst_flags", 32'({busy, ovr, ato}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      dn2_q.push_back('{10'd130, 9'd300, 10'd230, 9'd310, 1'b0, 1'b0});
      tick2 = 1'b1;
      @(negedge clk);
      tick2 = 1'b0;
      lat3_slot(10'd100, 9'd300);
      lat3_slot(10'd200, 9'd310);
      for (int i = 0; i < 40 && !done2; i++) @(negedge clk);
      if (!done2) expire("lat3_wait_done");
      repeat (5) @(negedge clk);

      chk("move_q_drained", 32'(mv_q.size()), 32'd0);
      chk("done_q_drained", 32'(dn_q.size()), 32'd0);
      chk("lat3_q_drained", 32'(dn2_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
